// File: rtl/syndrome_checker_pkg.sv
// -----------------------------------------------------------------------------
// dec_pkg
// Shared constants, types and GF(2^4) helpers for the RS(12,8) syndrome
// checker (receive-side detection front end).
//   - Geometry: EGF_ORDER bits/symbol, ENC_SYM_NUM symbols/beat,
//     DEC_BEATS beats/codeword, DEC_SYN_NUM syndromes.
//   - GF(2^4) with primitive polynomial x^4+x+1, alpha = 4'h2.
//   - gf_mul_const(): multiply by alpha^pow as a chain of shift/reduce
//     steps; with a constant pow this collapses to a pure XOR network.
//   - ALPHA_POW: alpha power table (alpha^0..alpha^14) for reference models.
// -----------------------------------------------------------------------------
package dec_pkg;

    localparam int EGF_ORDER   = 4;
    localparam int ENC_SYM_NUM = 4;
    localparam int DEC_BEATS   = 3;
    localparam int DEC_SYN_NUM = 4;

    localparam int BEAT_W     = ENC_SYM_NUM * EGF_ORDER;
    localparam int SYN_W      = DEC_SYN_NUM * EGF_ORDER;
    localparam int BEAT_CNT_W = $clog2(DEC_BEATS);

    // Multiplicative group order of GF(2^4).
    localparam int unsigned GF_GROUP_ORDER = 32'd15;

    localparam logic [4:0] GF_POLY = 5'b10011;

    typedef logic [EGF_ORDER-1:0]  egf_sym_t;
    typedef logic [BEAT_CNT_W-1:0] beat_cnt_t;

    localparam egf_sym_t ALPHA_POW [15] = '{
        4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h6, 4'hC, 4'hB,
        4'h5, 4'hA, 4'h7, 4'hE, 4'hF, 4'hD, 4'h9
    };

    // Multiply by alpha: shift up one degree, fold x^4 back with x+1.
    function automatic egf_sym_t gf_mul_alpha(input egf_sym_t sym);
        egf_sym_t res;
        res = {sym[EGF_ORDER-2:0], 1'b0};
        if (sym[EGF_ORDER-1]) begin
            res = res ^ GF_POLY[EGF_ORDER-1:0];
        end else begin
            res = res;
        end
        return res;
    endfunction

    // Multiply by alpha^pow. The loop has a fixed trip count so that a
    // constant pow unrolls into a fixed XOR network.
    function automatic egf_sym_t gf_mul_const(input egf_sym_t sym, input int unsigned pow);
        egf_sym_t    acc;
        int unsigned steps;
        acc   = sym;
        steps = pow % GF_GROUP_ORDER;
        for (int unsigned k = 32'd0; k < GF_GROUP_ORDER; k++) begin
            if (k < steps) begin
                acc = gf_mul_alpha(acc);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/syndrome_checker_if.sv
// -----------------------------------------------------------------------------
// syndrome_checker_if
// Bus bundle between a codeword source/sink and syndrome_checker.
//   data_in   : codeword beat, MSB symbol = highest-degree coefficient
//   in_valid  : data_in accepted this cycle (no backpressure)
//   data_out  : forwarded message beat
//   out_valid : data_out holds a message beat
//   syn_out   : {S1,S2,S3,S4}, S1 in the MSBs
//   syn_valid : one-cycle pulse when syn_out updates
//   err       : OR-reduction of syn_out
// master = testbench / upstream side, slave = checker.
// -----------------------------------------------------------------------------
interface syndrome_checker_if;
    import dec_pkg::*;

    logic [BEAT_W-1:0] data_in;
    logic              in_valid;
    logic [BEAT_W-1:0] data_out;
    logic              out_valid;
    logic [SYN_W-1:0]  syn_out;
    logic              syn_valid;
    logic              err;

    modport master (
        output data_in, in_valid,
        input  data_out, out_valid, syn_out, syn_valid, err
    );

    modport slave (
        input  data_in, in_valid,
        output data_out, out_valid, syn_out, syn_valid, err
    );

endinterface

// File: rtl/syndrome_checker_syn_step.sv
// -----------------------------------------------------------------------------
// dec_syn_step
// Combinational Horner step for all syndromes over one beat {a,b,c,d}:
//   S_i' = P_i*alpha^(4i) ^ a*alpha^(3i) ^ b*alpha^(2i) ^ c*alpha^i ^ d
// where P_i is the previous syndrome, or zero on the first beat of a
// codeword so that codewords may run back-to-back.
// Ports:
//   syn_prev_i   : previous syndrome vector {S1..S4}, S1 in MSBs
//   beat_i       : current codeword beat
//   first_beat_i : beat is the first of a codeword (ignore syn_prev_i)
//   syn_next_o   : updated syndrome vector
// -----------------------------------------------------------------------------
module dec_syn_step
    import dec_pkg::*;
(
    input  logic [SYN_W-1:0]  syn_prev_i,
    input  logic [BEAT_W-1:0] beat_i,
    input  logic              first_beat_i,
    output logic [SYN_W-1:0]  syn_next_o
);

    for (genvar gi = 0; gi < DEC_SYN_NUM; gi++) begin : g_syn
        // Syndrome index i runs 1..DEC_SYN_NUM; S1 sits in the top slice.
        localparam int unsigned IDX    = gi + 1;
        localparam int          SYN_HI = SYN_W - 1 - gi * EGF_ORDER;

        egf_sym_t prev_s;
        egf_sym_t chain_s [ENC_SYM_NUM+1];

        assign prev_s     = first_beat_i ? '0 : syn_prev_i[SYN_HI -: EGF_ORDER];
        assign chain_s[0] = gf_mul_const(prev_s, ENC_SYM_NUM * IDX);

        for (genvar gk = 0; gk < ENC_SYM_NUM; gk++) begin : g_sym
            // Symbol gk counted from the MSB has degree ENC_SYM_NUM-1-gk.
            localparam int BEAT_HI = BEAT_W - 1 - gk * EGF_ORDER;
            assign chain_s[gk+1] = chain_s[gk]
                                 ^ gf_mul_const(beat_i[BEAT_HI -: EGF_ORDER],
                                                (ENC_SYM_NUM - 1 - gk) * IDX);
        end

        assign syn_next_o[SYN_HI -: EGF_ORDER] = chain_s[ENC_SYM_NUM];
    end

endmodule

// File: rtl/syndrome_checker.sv
// -----------------------------------------------------------------------------
// syndrome_checker
// Receives shortened RS(12,8) codewords (3 beats of 4 symbols), forwards the
// two message beats and reports the four syndromes plus an error flag once
// the parity beat has been accepted. Always ready, one beat per cycle.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus_if : syndrome_checker_if.slave (data_in/in_valid in,
//            data_out/out_valid/syn_out/syn_valid/err out, all registered)
// -----------------------------------------------------------------------------
module syndrome_checker
    import dec_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    syndrome_checker_if.slave        bus_if
);

    localparam beat_cnt_t LAST_BEAT = beat_cnt_t'(DEC_BEATS - 1);

    beat_cnt_t         beat_cnt_q,  beat_cnt_d;
    logic [SYN_W-1:0]  syn_acc_q,   syn_acc_d;
    logic [BEAT_W-1:0] data_out_q,  data_out_d;
    logic              out_valid_q, out_valid_d;
    logic [SYN_W-1:0]  syn_out_q,   syn_out_d;
    logic              syn_valid_q, syn_valid_d;
    logic              err_q,       err_d;

    logic              first_beat_s;
    logic              last_beat_s;
    logic [SYN_W-1:0]  syn_next_s;

    assign first_beat_s = (beat_cnt_q == '0);
    assign last_beat_s  = (beat_cnt_q == LAST_BEAT);

    dec_syn_step u_syn_step (
        .syn_prev_i   (syn_acc_q),
        .beat_i       (bus_if.data_in),
        .first_beat_i (first_beat_s),
        .syn_next_o   (syn_next_s)
    );

    // Next-state: beat counter, accumulator and output registers.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        syn_acc_d   = syn_acc_q;
        data_out_d  = data_out_q;
        out_valid_d = 1'b0;
        syn_out_d   = syn_out_q;
        syn_valid_d = 1'b0;
        err_d       = err_q;
        if (bus_if.in_valid) begin
            syn_acc_d = syn_next_s;
            if (last_beat_s) begin
                beat_cnt_d  = '0;
                syn_out_d   = syn_next_s;
                syn_valid_d = 1'b1;
                err_d       = |syn_next_s;
            end else begin
                beat_cnt_d  = beat_cnt_q + beat_cnt_t'(1);
                data_out_d  = bus_if.data_in;
                out_valid_d = 1'b1;
            end
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // State and output registers; reset discards any partial codeword.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            syn_acc_q   <= '0;
            data_out_q  <= '0;
            out_valid_q <= 1'b0;
            syn_out_q   <= '0;
            syn_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            syn_acc_q   <= syn_acc_d;
            data_out_q  <= data_out_d;
            out_valid_q <= out_valid_d;
            syn_out_q   <= syn_out_d;
            syn_valid_q <= syn_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus_if.data_out  = data_out_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.syn_out   = syn_out_q;
    assign bus_if.syn_valid = syn_valid_q;
    assign bus_if.err       = err_q;

endmodule

// File: tb/tb_syndrome_checker.sv
// -----------------------------------------------------------------------------
// tb_syndrome_checker
// Directed, table-driven bench for syndrome_checker: hand-computed codeword
// vectors applied back-to-back, plus sequences for gaps, mid-codeword reset
// and a direct-evaluation reference model for a few random words.
// -----------------------------------------------------------------------------
module tb_syndrome_checker;
    import dec_pkg::*;

    logic clk;
    logic rst_n;

    syndrome_checker_if ifc ();

    syndrome_checker dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;
    int cycle  = 0;

    typedef struct {
        logic [15:0] b0;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [15:0] syn;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present one input cycle, then return just after the capturing edge.
    task automatic drive(input logic v, input logic [15:0] d);
        ifc.in_valid = v;
        ifc.data_in  = d;
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"},  ifc.data_out,  32'h0);
        check({tag, "_out_valid"}, ifc.out_valid, 32'h0);
        check({tag, "_syn_out"},   ifc.syn_out,   32'h0);
        check({tag, "_syn_valid"}, ifc.syn_valid, 32'h0);
        check({tag, "_err"},       ifc.err,       32'h0);
    endtask

    // Reference model: evaluate c(alpha^i) directly with log/antilog tables.
    function automatic logic [3:0] gmul(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] pw [15];
        int lx, ly;
        pw = ALPHA_POW;
        if (x == 4'h0 || y == 4'h0) return 4'h0;
        lx = 0; ly = 0;
        for (int k = 0; k < 15; k++) begin
            if (pw[k] == x) lx = k;
            if (pw[k] == y) ly = k;
        end
        return pw[(lx + ly) % 15];
    endfunction

    function automatic logic [15:0] model_syn(input logic [47:0] cw);
        logic [3:0]  pw [15];
        logic [3:0]  s;
        logic [15:0] res;
        pw  = ALPHA_POW;
        res = 16'h0;
        for (int i = 1; i <= 4; i++) begin
            s = 4'h0;
            for (int j = 0; j < 12; j++) begin
                s = s ^ gmul(cw[j*4 +: 4], pw[(i * j) % 15]);
            end
            res[(4 - i) * 4 +: 4] = s;
        end
        return res;
    endfunction

    initial begin
        int          last_sv;
        logic [47:0] cw;
        logic [15:0] exp_syn;

        // b0 = c11..c8, b1 = c7..c4, b2 = c3..c0
        vecs[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // all zero
        vecs[1] = '{16'h0000, 16'h0000, 16'h0001, 16'h1111, 1'b1}; // c0 = 1
        vecs[2] = '{16'h0000, 16'h0000, 16'h0010, 16'h2483, 1'b1}; // c1 = 1
        vecs[3] = '{16'h1000, 16'h0000, 16'h0000, 16'hEB89, 1'b1}; // c11 = 1
        vecs[4] = '{16'h0000, 16'h0001, 16'h0000, 16'h35F2, 1'b1}; // c4 = 1
        vecs[5] = '{16'h0001, 16'h0000, 16'h0000, 16'h52A4, 1'b1}; // c8 = 1
        vecs[6] = '{16'h0123, 16'h4567, 16'h9513, 16'h0000, 1'b0}; // valid codeword
        vecs[7] = '{16'h0000, 16'h0000, 16'h0011, 16'h3592, 1'b1}; // c1 = c0 = 1

        // Reset state
        rst_n        = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.data_in  = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table vectors, back-to-back
        last_sv = 0;
        for (int v = 0; v < 8; v++) begin
            drive(1'b1, vecs[v].b0);
            check($sformatf("v%0d_b0_data", v),      ifc.data_out,  {16'h0, vecs[v].b0});
            check($sformatf("v%0d_b0_ovalid", v),    ifc.out_valid, 32'h1);
            check($sformatf("v%0d_b0_svalid", v),    ifc.syn_valid, 32'h0);
            drive(1'b1, vecs[v].b1);
            check($sformatf("v%0d_b1_data", v),      ifc.data_out,  {16'h0, vecs[v].b1});
            check($sformatf("v%0d_b1_ovalid", v),    ifc.out_valid, 32'h1);
            check($sformatf("v%0d_b1_svalid", v),    ifc.syn_valid, 32'h0);
            drive(1'b1, vecs[v].b2);
            check($sformatf("v%0d_b2_ovalid", v),    ifc.out_valid, 32'h0);
            check($sformatf("v%0d_b2_data_hold", v), ifc.data_out,  {16'h0, vecs[v].b1});
            check($sformatf("v%0d_svalid", v),       ifc.syn_valid, 32'h1);
            check($sformatf("v%0d_syn", v),          ifc.syn_out,   {16'h0, vecs[v].syn});
            check($sformatf("v%0d_err", v),          ifc.err,       {31'h0, vecs[v].err});
            if (v > 0) check($sformatf("v%0d_svalid_spacing", v), cycle - last_sv, 32'd3);
            last_sv = cycle;
        end

        // Reset mid-codeword: discard beats 0/1, outputs zero during reset
        drive(1'b1, 16'h1000);
        drive(1'b1, 16'h0001);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst_async");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("midrst_held");
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0000);
        check("postrst_b0_svalid", ifc.syn_valid, 32'h0);
        check("postrst_b0_ovalid", ifc.out_valid, 32'h1);
        drive(1'b1, 16'h0000);
        check("postrst_b1_svalid", ifc.syn_valid, 32'h0);
        drive(1'b1, 16'h0000);
        check("postrst_svalid", ifc.syn_valid, 32'h1);
        check("postrst_syn",    ifc.syn_out,   32'h0);
        check("postrst_err",    ifc.err,       32'h0);

        // Non-zero syndrome, then a gapped valid codeword (state holds in gaps)
        drive(1'b1, 16'h0000);
        drive(1'b1, 16'h0000);
        drive(1'b1, 16'h0011);
        check("pregap_syn", ifc.syn_out, 32'h3592);
        drive(1'b1, 16'h0123);
        check("gap_b0_data", ifc.data_out, 32'h0123);
        for (int g = 0; g < 2; g++) begin
            drive(1'b0, 16'hFFFF);
            check($sformatf("gap1_%0d_ovalid", g), ifc.out_valid, 32'h0);
            check($sformatf("gap1_%0d_data", g),   ifc.data_out,  32'h0123);
            check($sformatf("gap1_%0d_syn", g),    ifc.syn_out,   32'h3592);
            check($sformatf("gap1_%0d_err", g),    ifc.err,       32'h1);
        end
        drive(1'b1, 16'h4567);
        check("gap_b1_data",   ifc.data_out,  32'h4567);
        check("gap_b1_ovalid", ifc.out_valid, 32'h1);
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, 16'hAAAA);
            check($sformatf("gap2_%0d_ovalid", g), ifc.out_valid, 32'h0);
            check($sformatf("gap2_%0d_svalid", g), ifc.syn_valid, 32'h0);
        end
        drive(1'b1, 16'h9513);
        check("gap_svalid", ifc.syn_valid, 32'h1);
        check("gap_syn",    ifc.syn_out,   32'h0);
        check("gap_err",    ifc.err,       32'h0);
        drive(1'b0, 16'h0000);
        check("gap_tail_svalid", ifc.syn_valid, 32'h0);
        check("gap_tail_syn",    ifc.syn_out,   32'h0);

        // Random codewords against the direct-evaluation model
        for (int r = 0; r < 6; r++) begin
            cw = {$urandom(), $urandom_range(65535, 0)};
            exp_syn = model_syn(cw);
            drive(1'b1, cw[47:32]);
            drive(1'b1, cw[31:16]);
            check($sformatf("rnd%0d_b1_data", r), ifc.data_out, {16'h0, cw[31:16]});
            drive(1'b1, cw[15:0]);
            check($sformatf("rnd%0d_syn", r), ifc.syn_out, {16'h0, exp_syn});
            check($sformatf("rnd%0d_err", r), ifc.err,     {31'h0, |exp_syn});
        end

        drive(1'b0, 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
